perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of N_CNT event counters for VR16 retirement and performance monitoring.
//  Replaces the single-bit instruction-done flag: each channel registers its event pulse, then counts it.
//  Each channel has an enable, a sync clear, wrap/saturate arithmetic and a sticky overflow flag.
//  Sits beside the control path. Channel 0 is wired to instruction-done; the rest take stall, branch, mem events.
// PARAMETERS
//  N_CNT     4    number of counter channels (1..16)
//  CNT_W     16   counter width in bits (2..32)
//  ADDR_W    2    read address width; must be >= clog2(N_CNT)
//  SAT_MODE  0    0 = wrap max->0; 1 = saturate at max
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  evt       in   N_CNT   per-channel event pulse; 1 = one event this cycle
//  evt_q     out  N_CNT   evt registered one cycle (per-channel event flag)
//  cfg_we    in   1       load enable mask from cfg_en
//  cfg_en    in   N_CNT   new enable mask
//  clr       in   N_CNT   synchronous per-channel counter clear
//  freeze    in   1       global count inhibit
//  rd_en     in   1       read request
//  rd_addr   in   ADDR_W  channel to read
//  rd_data   out  CNT_W   read result
//  rd_valid  out  1       one-cycle pulse, rd_data valid
//  ovf       out  N_CNT   sticky overflow flags
//  ovf_clr   in   N_CNT   per-channel overflow flag clear
//  irq_mask  in   N_CNT   overflow interrupt mask (VR16_PERF_IRQ_EN only)
//  irq       out  1       overflow interrupt (VR16_PERF_IRQ_EN only)
// BEHAVIOUR
//  - Reset (async): cnt=0, evt_q=0, en=all-ones, ovf=0, rd_data=0, rd_valid=0, irq=0.
//  - Stage 1: evt_q <= evt every cycle. Unaffected by freeze or enable.
//  - Stage 2: cnt[i] increments by 1 when evt_q[i] & en[i] & ~freeze.
//    An event at cycle T is first visible in cnt at T+2.
//  - Clear priority: clr[i] wins over an increment in the same cycle; that event is lost.
//  - Arithmetic width is CNT_W.
//    Wrap: an increment at max gives 0 and sets ovf[i].
//    Sat: an increment at max holds max and sets ovf[i]. Every further attempted increment re-sets ovf[i].
//  - ovf[i] is cleared only by ovf_clr[i]. If set and clear occur in the same cycle, set wins.
//  - cfg_we at cycle T: en <= cfg_en at the T edge, so gating applies to increments from T+1.
//  - freeze: events arriving during freeze are dropped, not deferred. clr and ovf_clr still act.
//  - Read: rd_en at cycle T gives rd_valid=1 at T+1.
//    rd_data = cnt[rd_addr] as sampled at T, before that edge's update (no bypass).
//    rd_addr >= N_CNT gives rd_data=0 with rd_valid=1.
//    rd_data holds its value while rd_en=0. Back-to-back reads are allowed every cycle.
//  - Reset asserted mid-operation clears all state immediately. Counting resumes on the first edge after deassertion.
// CONFIGURATION
//  VR16_PERF_IRQ_EN defined:
//    irq_mask and irq ports exist.
//    irq <= |(ovf & irq_mask), registered, so irq lags ovf by one cycle. Level output, drops once ovf is cleared.
//  VR16_PERF_IRQ_EN undefined: irq_mask and irq ports are absent and no irq logic is built.
// STRUCTURE
//  Package vr16_perf_pkg:
//    SAT/WRAP mode constants, default CNT_W/N_CNT, clog2 helper for ADDR_W check.
//  Sub-module perf_counter_slice (one per channel, via generate):
//    holds cnt, ovf, wrap/sat logic and clear priority.
//  Top level holds evt_q, the en register, the read mux/register and irq.
//  Elaboration check: ADDR_W >= clog2(N_CNT), N_CNT and CNT_W within range.
// TESTING
//  1. Reset, then evt[0]=1 for 5 cycles -> evt_q[0] pulses T+1..T+5; cnt0=5 read back; other channels 0.
//  2. CNT_W=4, wrap: 17 events on ch1 -> cnt1=1, ovf[1]=1.
//     SAT_MODE=1: same stimulus -> cnt1=15, ovf[1]=1.
//  3. clr[2] and evt_q[2] in the same cycle -> cnt2=0.
//     ovf_clr[1] in the same cycle as an overflow -> ovf[1] stays 1.
//  4. cfg_we, cfg_en=4'b1110, then 3 events on every channel with freeze=1 for one of those cycles -> cnt0=0, cnt1..3=2.
//  5. rd_en on consecutive cycles, addr 0..3 then 5 -> rd_valid high 5 cycles; values match pre-edge counts; addr 5 gives 0.
//  6. Reset pulse during counting -> all outputs 0 immediately.
//     With VR16_PERF_IRQ_EN: overflow with irq_mask=1 -> irq=1 one cycle after ovf; cleared after ovf_clr.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared constants and helpers for the VR16 performance counter bank.
package vr16_perf_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int N_CNT_DEF = 4;
  localparam int CNT_W_DEF = 16;

  localparam int N_CNT_MAX = 16;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 32;

  // Address bits needed to select one of v channels (0 for a single channel).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the counter bank: request (rd_en/rd_addr) and registered response.
interface perf_counter_bank_if #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/perf_counter_bank_slice.sv
// One counter channel: count register, sticky overflow, wrap/saturate arithmetic.
// Latency: cnt updates on the edge that samples inc; no backpressure.
module perf_counter_slice
  import vr16_perf_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] AT_MAX_NEXT = (SAT_MODE == MODE_SAT) ? CNT_MAX : '0;

  logic at_max;
  logic ovf_set;

  assign at_max  = (cnt == CNT_MAX);
  // A cleared cycle swallows the event, so it can neither count nor overflow.
  assign ovf_set = inc & ~clr & at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= at_max ? AT_MAX_NEXT : cnt + CNT_W'(1);
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CNT event counters: registered events, enable mask, freeze, registered read port.
// Optional overflow interrupt built when VR16_PERF_IRQ_EN is defined.
module perf_counter_bank
  import vr16_perf_pkg::*;
#(
  parameter int N_CNT    = N_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ADDR_W   = 2,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CNT-1:0] evt,
  output logic [N_CNT-1:0] evt_q,
  input  logic             cfg_we,
  input  logic [N_CNT-1:0] cfg_en,
  input  logic [N_CNT-1:0] clr,
  input  logic             freeze,
  perf_counter_bank_if.slave rd,
  output logic [N_CNT-1:0] ovf,
  input  logic [N_CNT-1:0] ovf_clr
`ifdef VR16_PERF_IRQ_EN
  ,
  input  logic [N_CNT-1:0] irq_mask,
  output logic             irq
`endif
);

  if (N_CNT < 1 || N_CNT > N_CNT_MAX) begin : g_bad_n_cnt
    $error("perf_counter_bank: N_CNT out of range 1..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("perf_counter_bank: CNT_W out of range 2..32");
  end
  if (ADDR_W < clog2(N_CNT)) begin : g_bad_addr_w
    $error("perf_counter_bank: ADDR_W too narrow for N_CNT");
  end

  logic [N_CNT-1:0] en;
  logic [N_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt_arr [N_CNT];
  logic [CNT_W-1:0] rd_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
      en    <= '1;
    end else begin
      evt_q <= evt;
      if (cfg_we) en <= cfg_en;
    end
  end

  // Frozen cycles drop events outright; they are not held for later.
  assign inc = evt_q & en & {N_CNT{~freeze}};

  for (genvar i = 0; i < N_CNT; i++) begin : g_slice
    perf_counter_slice #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[i]),
      .clr     (clr[i]),
      .ovf_clr (ovf_clr[i]),
      .cnt     (cnt_arr[i]),
      .ovf     (ovf[i])
    );
  end

  // Addresses past the last channel match nothing and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (int'(rd.rd_addr) == i) rd_mux = cnt_arr[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= rd_mux;
    end
  end

`ifdef VR16_PERF_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(ovf & irq_mask);
  end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrapping and a saturating 4-bit bank driven by the same stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] evt, cfg_en, clr, ovf_clr;
  logic       cfg_we, freeze, rd_en;
  logic [2:0] rd_addr;
  logic [3:0] evt_q_w, evt_q_s, ovf_w, ovf_s;
`ifdef VR16_PERF_IRQ_EN
  logic [3:0] irq_mask;
  logic       irq_w, irq_s;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.ADDR_W(3), .CNT_W(4)) rd_w ();
  perf_counter_bank_if #(.ADDR_W(3), .CNT_W(4)) rd_s ();

  assign rd_w.rd_en   = rd_en;
  assign rd_w.rd_addr = rd_addr;
  assign rd_s.rd_en   = rd_en;
  assign rd_s.rd_addr = rd_addr;

  perf_counter_bank #(.N_CNT(4), .CNT_W(4), .ADDR_W(3), .SAT_MODE(0)) dut_w (
    .clk(clk), .reset(reset), .evt(evt), .evt_q(evt_q_w), .cfg_we(cfg_we),
    .cfg_en(cfg_en), .clr(clr), .freeze(freeze), .rd(rd_w.slave),
    .ovf(ovf_w), .ovf_clr(ovf_clr)
`ifdef VR16_PERF_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w)
`endif
  );

  perf_counter_bank #(.N_CNT(4), .CNT_W(4), .ADDR_W(3), .SAT_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .evt(evt), .evt_q(evt_q_s), .cfg_we(cfg_we),
    .cfg_en(cfg_en), .clr(clr), .freeze(freeze), .rd(rd_s.slave),
    .ovf(ovf_s), .ovf_clr(ovf_clr)
`ifdef VR16_PERF_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_s)
`endif
  );

  task automatic vec_chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp_w, input int exp_s);
    rd_en   = 1'b1;
    rd_addr = 3'(addr);
    tick();
    rd_en = 1'b0;
    vec_chk({tag, "_vld_w"}, 32'(rd_w.rd_valid), 1);
    vec_chk({tag, "_vld_s"}, 32'(rd_s.rd_valid), 1);
    vec_chk({tag, "_dat_w"}, 32'(rd_w.rd_data), exp_w);
    vec_chk({tag, "_dat_s"}, 32'(rd_s.rd_data), exp_s);
  endtask

  task automatic pulse_evt(input logic [3:0] mask, input int n);
    evt = mask;
    repeat (n) tick();
    evt = 4'b0;
    tick();
  endtask

  initial begin
    int addrs [5] = '{0, 1, 2, 3, 5};
    int exps  [5] = '{0, 2, 2, 2, 0};

    reset = 1'b1; evt = '0; cfg_we = 1'b0; cfg_en = '0; clr = '0;
    freeze = 1'b0; ovf_clr = '0; rd_en = 1'b0; rd_addr = '0;
`ifdef VR16_PERF_IRQ_EN
    irq_mask = '0;
`endif
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    vec_chk("rst_evt_q", 32'(evt_q_w), 0);
    vec_chk("rst_ovf", 32'({ovf_w, ovf_s}), 0);
    vec_chk("rst_rd_valid", 32'(rd_w.rd_valid), 0);
    vec_chk("rst_rd_data", 32'(rd_w.rd_data), 0);

    // Five events on channel 0: evt_q follows one cycle later, count lands one more later
    evt = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec_chk($sformatf("evt_q_%0d", k), 32'(evt_q_w), 32'h1);
    end
    evt = 4'b0;
    tick();
    vec_chk("evt_q_off", 32'(evt_q_w), 0);
    rd_chk("t1_c0", 0, 5, 5);
    rd_chk("t1_c1", 1, 0, 0);
    rd_chk("t1_c3", 3, 0, 0);

    // 17 events on channel 1: wrap gives 1, saturate holds 15
    pulse_evt(4'b0010, 17);
    vec_chk("t2_ovf_w", 32'(ovf_w), 32'h2);
    vec_chk("t2_ovf_s", 32'(ovf_s), 32'h2);
    rd_chk("t2_c1", 1, 1, 15);

    // Bring wrap ch1 to max, clear flags, then overflow in the same cycle as ovf_clr
    pulse_evt(4'b0010, 14);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = 4'b0;
    vec_chk("t3_ovf_clr_w", 32'(ovf_w), 0);
    vec_chk("t3_ovf_clr_s", 32'(ovf_s), 0);
    rd_chk("t3_c1_max", 1, 15, 15);
    evt = 4'b0010;
    tick();
    evt = 4'b0;
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = 4'b0;
    vec_chk("t3_set_wins_w", 32'(ovf_w), 32'h2);
    vec_chk("t3_set_wins_s", 32'(ovf_s), 32'h2);
    rd_chk("t3_c1_after", 1, 0, 15);

    // Clear on the cycle channel 2's third event would count
    evt = 4'b0100;
    repeat (3) tick();
    evt = 4'b0;
    clr = 4'b0100;
    tick();
    clr = 4'b0;
    tick();
    rd_chk("t3_clr_wins", 2, 0, 0);

    // Disable ch0, clear all, three events with the middle increment frozen
    cfg_we = 1'b1; cfg_en = 4'b1110; clr = 4'b1111;
    tick();
    cfg_we = 1'b0; clr = 4'b0;
    evt = 4'b1111;
    tick();
    tick();
    freeze = 1'b1;
    tick();
    freeze = 1'b0; evt = 4'b0;
    tick();
    tick();

    // Back-to-back reads; ch3 increments on the very edge that samples it
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1;
      rd_addr = 3'(addrs[k]);
      evt = (k == 2) ? 4'b1000 : 4'b0;
      tick();
      vec_chk($sformatf("t5_vld_%0d", k), 32'(rd_w.rd_valid), 1);
      vec_chk($sformatf("t5_dat_w_%0d", k), 32'(rd_w.rd_data), exps[k]);
      vec_chk($sformatf("t5_dat_s_%0d", k), 32'(rd_s.rd_data), exps[k]);
    end
    rd_en = 1'b0; evt = 4'b0;
    tick();
    vec_chk("t5_vld_drop", 32'(rd_w.rd_valid), 0);
    vec_chk("t5_dat_hold", 32'(rd_w.rd_data), 0);
    rd_chk("t5_c3_post", 3, 3, 3);

    // Asynchronous reset mid-count with a read in flight
    evt = 4'b1111; rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    tick();
    vec_chk("t6_pre_vld", 32'(rd_w.rd_valid), 1);
    #2 reset = 1'b1;
    #1;
    vec_chk("t6_evt_q", 32'({evt_q_w, evt_q_s}), 0);
    vec_chk("t6_ovf", 32'({ovf_w, ovf_s}), 0);
    vec_chk("t6_rd_valid", 32'({rd_w.rd_valid, rd_s.rd_valid}), 0);
    vec_chk("t6_rd_data", 32'({rd_w.rd_data, rd_s.rd_data}), 0);
    evt = 4'b0; rd_en = 1'b0;
    tick();
    reset = 1'b0;
    // Enable mask returns to all-ones, so ch0 counts again
    pulse_evt(4'b0001, 1);
    rd_chk("t6_c0", 0, 1, 1);
    rd_chk("t6_c3", 3, 0, 0);

`ifdef VR16_PERF_IRQ_EN
    irq_mask = 4'b0010;
    pulse_evt(4'b0010, 16);
    vec_chk("irq_ovf", 32'(ovf_w), 32'h2);
    vec_chk("irq_lag", 32'(irq_w), 0);
    tick();
    vec_chk("irq_set_w", 32'(irq_w), 1);
    vec_chk("irq_set_s", 32'(irq_s), 1);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = 4'b0;
    tick();
    vec_chk("irq_drop", 32'({irq_w, irq_s}), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
